// File: rtl/udp_tx_framer_if.sv
// Payload-in and frame-out streams of the UDP transmit framer.
// master = framer side, slave = FIFO/MAC side.
interface udp_tx_framer_if;
  logic [31:0] data_in;
  logic        data_in_vld;
  logic        data_in_rd;
  logic [31:0] data_out;
  logic [1:0]  be_out;
  logic        data_out_rdy;
  logic        data_out_rd;
  logic        sop;
  logic        eop;

  modport master (
    input  data_in, data_in_vld, data_out_rd,
    output data_in_rd, data_out, be_out, data_out_rdy, sop, eop
  );

  modport slave (
    output data_in, data_in_vld, data_out_rd,
    input  data_in_rd, data_out, be_out, data_out_rdy, sop, eop
  );
endinterface

// File: rtl/udp_tx_framer.sv
// Ethernet/IPv4/UDP frame generator: latches header fields on start, computes
// IP/UDP checksums in one cycle, then streams header and payload words.
module udp_tx_framer #(
  parameter int unsigned VLAN_EN   = 0,
  parameter int unsigned CHKSUM_EN = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [47:0]  mac_dst_addr,
  input  logic [47:0]  mac_src_addr,
  input  logic [15:0]  mac_type,
  input  logic [15:0]  vlan_tci,
  input  logic [7:0]   ip_dsf,
  input  logic [15:0]  ip_id,
  input  logic [2:0]   ip_flag,
  input  logic [12:0]  ip_frag_offset,
  input  logic [7:0]   ip_ttl,
  input  logic [7:0]   ip_prot,
  input  logic [31:0]  ip_src_addr,
  input  logic [31:0]  ip_dst_addr,
  input  logic [15:0]  udp_src_port,
  input  logic [15:0]  udp_dst_port,
  input  logic [15:0]  udp_data_length,
  input  logic [15:0]  udp_data_chksum,
  output logic         busy,
  output logic         len_err,
  udp_tx_framer_if.master bus
);

  localparam logic [15:0] MAX_LEN = 16'd65507;
  localparam logic [3:0]  HLAST   = 4'(9 + VLAN_EN);

  typedef enum logic [1:0] {IDLE, CALC, HDR, PAY} state_t;

  state_t      state_q;
  logic        busy_q, len_err_q;
  logic [47:0] dst_q, src_q;
  logic [15:0] type_q, tci_q, id_q, sport_q, dport_q, len_q, dchk_q;
  logic [7:0]  dsf_q, ttl_q, prot_q;
  logic [2:0]  flag_q;
  logic [12:0] frag_q;
  logic [31:0] sip_q, dip_q;
  logic [15:0] tot_len_q, udp_len_q, ip_cs_q, udp_cs_q;
  logic [3:0]  widx_q;
  logic        first_q;
  logic [15:0] rem_q, hold_q;

  logic [15:0] tot_len_d, udp_len_d, ip_cs_d, udp_cs_d, udp_cs_raw;
  logic [19:0] ip_sum, udp_sum;
  logic [3:0]  hsel;
  logic [31:0] word_d;
  logic [1:0]  be_d;
  logic        need_d, last_d, rdy_d, xfer;
  logic [15:0] step_d;

  // Two end-around-carry folds of a 20-bit sum always leave no carry.
  function automatic logic [15:0] fold16(input logic [19:0] s);
    logic [16:0] f;
    f = 17'(s[15:0]) + 17'(s[19:16]);
    return f[15:0] + 16'(f[16]);
  endfunction

  always_comb begin
    tot_len_d = len_q + 16'd28;
    udp_len_d = len_q + 16'd8;
    ip_sum = 20'({8'h45, dsf_q}) + 20'(tot_len_d) + 20'(id_q)
           + 20'({flag_q, frag_q}) + 20'({ttl_q, prot_q})
           + 20'(sip_q[31:16]) + 20'(sip_q[15:0])
           + 20'(dip_q[31:16]) + 20'(dip_q[15:0]);
    udp_sum = 20'(sip_q[31:16]) + 20'(sip_q[15:0])
            + 20'(dip_q[31:16]) + 20'(dip_q[15:0])
            + 20'({8'h00, prot_q}) + 20'(udp_len_d)
            + 20'(sport_q) + 20'(dport_q) + 20'(udp_len_d) + 20'(dchk_q);
    ip_cs_d    = ~fold16(ip_sum);
    udp_cs_raw = ~fold16(udp_sum);
    if (CHKSUM_EN == 0)          udp_cs_d = '0;
    else if (udp_cs_raw == '0)   udp_cs_d = '1;
    else                         udp_cs_d = udp_cs_raw;
  end

  always_comb begin
    word_d = '0;
    be_d   = 2'b00;
    need_d = 1'b0;
    last_d = 1'b0;
    step_d = '0;
    hsel   = widx_q;
    if (widx_q >= 4'd3) hsel = widx_q - 4'(VLAN_EN);
    case (state_q)
      HDR: begin
        if (VLAN_EN != 0 && widx_q == 4'd3) word_d = {16'h8100, tci_q};
        else begin
          case (hsel)
            4'd0:    word_d = dst_q[47:16];
            4'd1:    word_d = {dst_q[15:0], src_q[47:32]};
            4'd2:    word_d = src_q[31:0];
            4'd3:    word_d = {type_q, 8'h45, dsf_q};
            4'd4:    word_d = {tot_len_q, id_q};
            4'd5:    word_d = {flag_q, frag_q, ttl_q, prot_q};
            4'd6:    word_d = {ip_cs_q, sip_q[31:16]};
            4'd7:    word_d = {sip_q[15:0], dip_q[31:16]};
            4'd8:    word_d = {dip_q[15:0], sport_q};
            4'd9:    word_d = {dport_q, udp_len_q};
            default: word_d = '0;
          endcase
        end
      end
      PAY: begin
        // rem_q counts payload bytes not yet sent; the first word carries
        // only two payload bytes behind the UDP checksum.
        if (first_q) begin
          need_d = (rem_q != '0);
          last_d = (rem_q <= 16'd2);
          step_d = (rem_q >= 16'd2) ? 16'd2 : rem_q;
          be_d   = (rem_q == '0) ? 2'b10 : (rem_q == 16'd1) ? 2'b11 : 2'b00;
          word_d = {udp_cs_q, need_d ? bus.data_in[31:16] : 16'h0000};
        end else begin
          need_d = (rem_q > 16'd2);
          last_d = (rem_q <= 16'd4);
          step_d = (rem_q >= 16'd4) ? 16'd4 : rem_q;
          be_d   = (rem_q >= 16'd4) ? 2'b00 : rem_q[1:0];
          word_d = {hold_q, need_d ? bus.data_in[31:16] : 16'h0000};
        end
      end
      default: ;
    endcase
    rdy_d = (state_q == HDR) || (state_q == PAY && (!need_d || bus.data_in_vld));
    xfer  = rdy_d && bus.data_out_rd;
  end

  assign bus.data_out_rdy = rdy_d;
  assign bus.data_out     = rdy_d ? word_d : '0;
  assign bus.be_out       = rdy_d ? be_d : 2'b00;
  assign bus.sop          = (state_q == HDR) && (widx_q == '0);
  assign bus.eop          = (state_q == PAY) && rdy_d && last_d;
  assign bus.data_in_rd   = (state_q == PAY) && need_d && bus.data_in_vld && bus.data_out_rd;
  assign busy             = busy_q;
  assign len_err          = len_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      len_err_q <= 1'b0;
      dst_q     <= '0;  src_q   <= '0;  type_q <= '0;  tci_q  <= '0;
      dsf_q     <= '0;  id_q    <= '0;  flag_q <= '0;  frag_q <= '0;
      ttl_q     <= '0;  prot_q  <= '0;  sip_q  <= '0;  dip_q  <= '0;
      sport_q   <= '0;  dport_q <= '0;  len_q  <= '0;  dchk_q <= '0;
      tot_len_q <= '0;  udp_len_q <= '0;  ip_cs_q <= '0;  udp_cs_q <= '0;
      widx_q    <= '0;  first_q <= 1'b0;  rem_q <= '0;  hold_q <= '0;
    end else begin
      len_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (udp_data_length > MAX_LEN) begin
              len_err_q <= 1'b1;
            end else begin
              dst_q   <= mac_dst_addr;   src_q   <= mac_src_addr;
              type_q  <= mac_type;       tci_q   <= vlan_tci;
              dsf_q   <= ip_dsf;         id_q    <= ip_id;
              flag_q  <= ip_flag;        frag_q  <= ip_frag_offset;
              ttl_q   <= ip_ttl;         prot_q  <= ip_prot;
              sip_q   <= ip_src_addr;    dip_q   <= ip_dst_addr;
              sport_q <= udp_src_port;   dport_q <= udp_dst_port;
              len_q   <= udp_data_length; dchk_q <= udp_data_chksum;
              rem_q   <= udp_data_length;
              busy_q  <= 1'b1;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          tot_len_q <= tot_len_d;
          udp_len_q <= udp_len_d;
          ip_cs_q   <= ip_cs_d;
          udp_cs_q  <= udp_cs_d;
          widx_q    <= '0;
          first_q   <= 1'b1;
          state_q   <= HDR;
        end
        HDR: begin
          if (xfer) begin
            if (widx_q == HLAST) state_q <= PAY;
            else                 widx_q  <= widx_q + 4'd1;
          end
        end
        PAY: begin
          if (xfer) begin
            rem_q   <= rem_q - step_d;
            first_q <= 1'b0;
            if (need_d) hold_q <= bus.data_in[15:0];
            if (last_d) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_framer.sv
// Randomized bench for udp_tx_framer: a byte-level frame model is compared
// against every transferred word, plus fixed-value checks on known frames.
module tb_udp_tx_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  start_v;
  logic [47:0] mac_dst_addr, mac_src_addr;
  logic [15:0] mac_type, vlan_tci, ip_id, udp_src_port, udp_dst_port;
  logic [15:0] udp_data_length, udp_data_chksum;
  logic [7:0]  ip_dsf, ip_ttl, ip_prot;
  logic [2:0]  ip_flag;
  logic [12:0] ip_frag_offset;
  logic [31:0] ip_src_addr, ip_dst_addr;
  logic [31:0] din;
  logic        din_vld, out_rd;
  logic [2:0]  busy_v, len_err_v;

  udp_tx_framer_if if0();
  udp_tx_framer_if if1();
  udp_tx_framer_if if2();

  assign if0.data_in = din;  assign if0.data_in_vld = din_vld;  assign if0.data_out_rd = out_rd;
  assign if1.data_in = din;  assign if1.data_in_vld = din_vld;  assign if1.data_out_rd = out_rd;
  assign if2.data_in = din;  assign if2.data_in_vld = din_vld;  assign if2.data_out_rd = out_rd;

  udp_tx_framer #(.VLAN_EN(0), .CHKSUM_EN(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]),
    .mac_dst_addr(mac_dst_addr), .mac_src_addr(mac_src_addr), .mac_type(mac_type),
    .vlan_tci(vlan_tci), .ip_dsf(ip_dsf), .ip_id(ip_id), .ip_flag(ip_flag),
    .ip_frag_offset(ip_frag_offset), .ip_ttl(ip_ttl), .ip_prot(ip_prot),
    .ip_src_addr(ip_src_addr), .ip_dst_addr(ip_dst_addr),
    .udp_src_port(udp_src_port), .udp_dst_port(udp_dst_port),
    .udp_data_length(udp_data_length), .udp_data_chksum(udp_data_chksum),
    .busy(busy_v[0]), .len_err(len_err_v[0]), .bus(if0.master));

  udp_tx_framer #(.VLAN_EN(1), .CHKSUM_EN(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]),
    .mac_dst_addr(mac_dst_addr), .mac_src_addr(mac_src_addr), .mac_type(mac_type),
    .vlan_tci(vlan_tci), .ip_dsf(ip_dsf), .ip_id(ip_id), .ip_flag(ip_flag),
    .ip_frag_offset(ip_frag_offset), .ip_ttl(ip_ttl), .ip_prot(ip_prot),
    .ip_src_addr(ip_src_addr), .ip_dst_addr(ip_dst_addr),
    .udp_src_port(udp_src_port), .udp_dst_port(udp_dst_port),
    .udp_data_length(udp_data_length), .udp_data_chksum(udp_data_chksum),
    .busy(busy_v[1]), .len_err(len_err_v[1]), .bus(if1.master));

  udp_tx_framer #(.VLAN_EN(0), .CHKSUM_EN(0)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]),
    .mac_dst_addr(mac_dst_addr), .mac_src_addr(mac_src_addr), .mac_type(mac_type),
    .vlan_tci(vlan_tci), .ip_dsf(ip_dsf), .ip_id(ip_id), .ip_flag(ip_flag),
    .ip_frag_offset(ip_frag_offset), .ip_ttl(ip_ttl), .ip_prot(ip_prot),
    .ip_src_addr(ip_src_addr), .ip_dst_addr(ip_dst_addr),
    .udp_src_port(udp_src_port), .udp_dst_port(udp_dst_port),
    .udp_data_length(udp_data_length), .udp_data_chksum(udp_data_chksum),
    .busy(busy_v[2]), .len_err(len_err_v[2]), .bus(if2.master));

  int sel;
  logic [31:0] o_data;
  logic [1:0]  o_be;
  logic        o_rdy, o_sop, o_eop, o_rdin, o_busy, o_lerr;

  always_comb begin
    o_busy = busy_v[sel];
    o_lerr = len_err_v[sel];
    case (sel)
      1: begin o_data = if1.data_out; o_be = if1.be_out; o_rdy = if1.data_out_rdy;
               o_sop = if1.sop; o_eop = if1.eop; o_rdin = if1.data_in_rd; end
      2: begin o_data = if2.data_out; o_be = if2.be_out; o_rdy = if2.data_out_rdy;
               o_sop = if2.sop; o_eop = if2.eop; o_rdin = if2.data_in_rd; end
      default: begin o_data = if0.data_out; o_be = if0.be_out; o_rdy = if0.data_out_rdy;
               o_sop = if0.sop; o_eop = if0.eop; o_rdin = if0.data_in_rd; end
    endcase
  end

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  pay[$];
  logic [7:0]  fb[$];
  logic [31:0] exp_w[$];
  logic [1:0]  exp_be[$];
  int          exp_nb[$];
  logic [31:0] cap_w[$];
  logic [1:0]  cap_be[$];
  int got, pops, src_ptr, nwp, pv, pr;
  bit active = 1'b0;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  function automatic logic [15:0] fold(input int unsigned s);
    while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
    return s[15:0];
  endfunction

  function automatic int unsigned fb_hsum(input int from, input int n);
    int unsigned s = 0;
    for (int i = 0; i < n; i += 2) s += {fb[from + i], fb[from + i + 1]};
    return s;
  endfunction

  function automatic logic [15:0] pay_chksum();
    int unsigned s = 0;
    for (int i = 0; i < pay.size(); i += 2)
      s += {pay[i], (i + 1 < pay.size()) ? pay[i + 1] : 8'h00};
    return fold(s);
  endfunction

  task automatic push_n(input logic [47:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) fb.push_back(v[8 * i +: 8]);
  endtask

  // Frame as a byte string, then sliced into 32-bit words.
  task automatic build_model(input bit vlan, input bit csen);
    int ipo, uo, n, nw;
    logic [15:0] tot, ul, ipcs, ucs;
    logic [31:0] w;
    tot = udp_data_length + 16'd28;
    ul  = udp_data_length + 16'd8;
    fb.delete();
    push_n(mac_dst_addr, 6);
    push_n(mac_src_addr, 6);
    if (vlan) begin push_n(48'h8100, 2); push_n(48'(vlan_tci), 2); end
    push_n(48'(mac_type), 2);
    ipo = fb.size();
    push_n(48'h45, 1);  push_n(48'(ip_dsf), 1);
    push_n(48'(tot), 2); push_n(48'(ip_id), 2);
    push_n(48'({ip_flag, ip_frag_offset}), 2);
    push_n(48'(ip_ttl), 1); push_n(48'(ip_prot), 1);
    push_n(48'h0, 2);
    push_n(48'(ip_src_addr), 4); push_n(48'(ip_dst_addr), 4);
    ipcs = ~fold(fb_hsum(ipo, 20));
    fb[ipo + 10] = ipcs[15:8];
    fb[ipo + 11] = ipcs[7:0];
    uo = fb.size();
    push_n(48'(udp_src_port), 2); push_n(48'(udp_dst_port), 2);
    push_n(48'(ul), 2); push_n(48'h0, 2);
    ucs = ~fold(fb_hsum(ipo + 12, 8) + ip_prot + ul + fb_hsum(uo, 8) + udp_data_chksum);
    if (!csen) ucs = 16'h0000;
    else if (ucs == 16'h0000) ucs = 16'hFFFF;
    fb[uo + 6] = ucs[15:8];
    fb[uo + 7] = ucs[7:0];
    foreach (pay[i]) fb.push_back(pay[i]);
    n  = fb.size();
    nw = (n + 3) / 4;
    exp_w.delete(); exp_be.delete(); exp_nb.delete();
    for (int i = 0; i < nw; i++) begin
      w = '0;
      for (int b = 0; b < 4; b++) if (4 * i + b < n) w[31 - 8 * b -: 8] = fb[4 * i + b];
      exp_w.push_back(w);
      exp_nb.push_back((i == nw - 1) ? n - 4 * i : 4);
      exp_be.push_back(2'(exp_nb[i]));
    end
  endtask

  function automatic logic [31:0] src_word(input int p);
    logic [31:0] w = 32'hA5A5A5A5;
    for (int b = 0; b < 4; b++) if (4 * p + b < pay.size()) w[31 - 8 * b -: 8] = pay[4 * p + b];
    return w;
  endfunction

  // Single compare process: every transferred word against the model.
  always @(negedge clk) begin
    logic [31:0] m;
    if (active && rst_n) begin
      if (o_rdin && !o_rdy) chk("rd_while_not_rdy", 1, 0);
      if (o_rdin) begin pops++; src_ptr++; end
      if (o_rdy && out_rd) begin
        if (got >= exp_w.size()) chk("extra_word", got, exp_w.size());
        else begin
          m = 32'hFFFFFFFF << (8 * (4 - exp_nb[got]));
          chk($sformatf("word%0d", got),
              {o_data & m, o_be, o_sop, o_eop},
              {exp_w[got] & m, exp_be[got], got == 0, got == exp_w.size() - 1});
          cap_w.push_back(o_data);
          cap_be.push_back(o_be);
          got++;
        end
      end
    end
  end

  task automatic drive_inputs();
    din_vld = (src_ptr < nwp) && ($urandom_range(99) < pv);
    out_rd  = ($urandom_range(99) < pr);
    din     = src_word(src_ptr);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk(nm, {o_data, o_be, o_rdy, o_sop, o_eop, o_rdin, o_busy, o_lerr}, '0);
  endtask

  task automatic rand_hdr();
    mac_dst_addr = {$urandom, $urandom}; mac_src_addr = {$urandom, $urandom};
    mac_type = $urandom; vlan_tci = $urandom; ip_dsf = $urandom; ip_id = $urandom;
    ip_flag = $urandom; ip_frag_offset = $urandom; ip_ttl = $urandom; ip_prot = $urandom;
    ip_src_addr = $urandom; ip_dst_addr = $urandom;
    udp_src_port = $urandom; udp_dst_port = $urandom;
  endtask

  task automatic run_frame(input int s, input int len, input int pvv, input int prv,
                           input bit keep_pay, input bit mid_start, input int abort_at);
    bit done = 1'b0;
    sel = s;
    udp_data_length = 16'(len);
    if (!keep_pay) begin
      pay.delete();
      for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
    end
    udp_data_chksum = pay_chksum();
    build_model(s == 1, s != 2);
    pv = pvv; pr = prv; nwp = (len + 3) / 4;
    got = 0; pops = 0; src_ptr = 0;
    cap_w.delete(); cap_be.delete();
    din_vld = 1'b0; out_rd = 1'b0;
    active = 1'b1;
    @(posedge clk); #1 start_v[s] = 1'b1;
    @(posedge clk); #1 start_v[s] = 1'b0;
    chk("busy_cycle1", {o_busy, o_rdy}, 2'b10);
    drive_inputs();
    @(posedge clk); #1;
    chk("sop_cycle2", {o_rdy, o_sop, o_data}, {2'b11, exp_w[0]});
    for (int c = 0; c < 20000; c++) begin
      if (got == exp_w.size() && !o_busy) begin done = 1'b1; break; end
      if (abort_at != 0 && c == abort_at) begin
        active = 1'b0;
        rst_n = 1'b0;
        #1 check_reset_outputs("reset_mid_frame");
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("reset_held");
        rst_n = 1'b1;
        din_vld = 1'b0; out_rd = 1'b0;
        return;
      end
      if (mid_start && c == 5) begin start_v[s] = 1'b1; ip_id = ~ip_id; end
      if (mid_start && c == 6) start_v[s] = 1'b0;
      drive_inputs();
      @(posedge clk); #1;
    end
    active = 1'b0;
    din_vld = 1'b0; out_rd = 1'b0;
    chk("frame_done", done, 1);
    chk("frame_words", got, exp_w.size());
    chk("pop_count", pops, nwp);
  endtask

  initial begin
    int lens [5] = '{0, 1, 2, 3, 5};
    int nws  [5] = '{11, 11, 11, 12, 12};
    int bes  [5] = '{2, 3, 0, 1, 3};
    int rds  [5] = '{0, 1, 1, 1, 2};
    logic [15:0] ps;

    rst_n = 1'b1; start_v = '0; din = '0; din_vld = 1'b0; out_rd = 1'b0; sel = 0;
    rand_hdr(); udp_data_length = '0; udp_data_chksum = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset_state");
    rst_n = 1'b1;

    // Known header
    ip_dsf = 8'h00; ip_id = 16'h0000; ip_flag = 3'b010; ip_frag_offset = '0;
    ip_ttl = 8'h40; ip_prot = 8'h11;
    ip_src_addr = 32'hC0A80001; ip_dst_addr = 32'hC0A800C7;
    run_frame(0, 87, 100, 100, 0, 0, 0);
    chk("hdr_w3_low", cap_w[3][15:0], 16'h4500);
    chk("hdr_w4", cap_w[4], 32'h0073_0000);
    chk("hdr_ipcs", cap_w[6][31:16], 16'hB861);
    chk("hdr_nwords", cap_w.size(), 33);
    chk("hdr_last_be", cap_be[32], 2'b01);
    chk("hdr_pops", pops, 22);

    foreach (lens[i]) begin
      rand_hdr();
      run_frame(0, lens[i], 100, 100, 0, 0, 0);
      chk($sformatf("small%0d_nwords", lens[i]), cap_w.size(), nws[i]);
      chk($sformatf("small%0d_last_be", lens[i]), cap_be[cap_be.size() - 1], bes[i]);
      chk($sformatf("small%0d_pops", lens[i]), pops, rds[i]);
    end

    rand_hdr(); vlan_tci = 16'h6064;
    run_frame(1, 8, 100, 100, 0, 0, 0);
    chk("vlan_w3", cap_w[3], 32'h8100_6064);
    chk("vlan_nwords", cap_w.size(), 14);
    chk("vlan_last_be", cap_be[13], 2'b10);

    rand_hdr();
    run_frame(0, 1000, 55, 60, 0, 1, 0);

    // Payload chosen so the one's-complement sum is FFFF
    rand_hdr();
    ps = fold(ip_src_addr[31:16] + ip_src_addr[15:0] + ip_dst_addr[31:16] + ip_dst_addr[15:0]
              + ip_prot + 32'd10 + udp_src_port + udp_dst_port + 32'd10);
    ps = 16'hFFFF - ps;
    pay.delete(); pay.push_back(ps[15:8]); pay.push_back(ps[7:0]);
    run_frame(0, 2, 100, 100, 1, 0, 0);
    chk("udpcs_ffff", cap_w[10][31:16], 16'hFFFF);

    rand_hdr();
    run_frame(2, 20, 80, 80, 0, 0, 0);
    chk("udpcs_disabled", cap_w[10][31:16], 16'h0000);

    sel = 0; udp_data_length = 16'd65508;
    @(posedge clk); #1 start_v[0] = 1'b1;
    @(posedge clk); #1 start_v[0] = 1'b0;
    chk("len_err_pulse", {o_lerr, o_busy, o_rdy}, 3'b100);
    @(posedge clk); #1;
    chk("len_err_after", {o_lerr, o_busy, o_rdy}, 3'b000);

    rand_hdr();
    run_frame(0, 200, 100, 100, 0, 0, 30);
    rand_hdr();
    run_frame(0, 40, 100, 100, 0, 0, 0);

    for (int k = 0; k < 6; k++) begin
      rand_hdr();
      run_frame($urandom_range(2), $urandom_range(300), $urandom_range(60, 100),
                $urandom_range(60, 100), 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
